rvv_vsetvl_unit: RTL
====================

# rvv_vsetvl_unit

Pipelined vector-configuration unit for the RVV backend. Executes `vsetvli`, `vsetivli` and `vsetvl` uops, computes VLMAX from VLEN/SEW/LMUL, derives the new `vl`, checks vtype legality, and returns the scalar `rd` value. It holds the architectural `vtype`/`vl` state that the dispatch stage reads. It generalises the fixed SEW8/16/32 and LMUL tables into a VLEN/ELEN-parametrised unit with a 2-stage valid/ready pipeline, in-flight forwarding and flush.

## Interface
- VLEN, 128, vector register length in bits; power of two, 64..1024
- XLEN, 32, scalar width
- ELEN, 32, max element width; 32 or 64
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill all in-flight uops; no architectural update
- in_valid / in_ready  in / out  1 / 1  uop handshake
- in_op  in  2  vset_op_e: 0 VSETVLI, 1 VSETIVLI, 2 VSETVL
- in_rs1_x0, in_rd_x0  in  1 each  rs1 field is x0; rd field is x0
- in_avl  in  XLEN  rs1 value, or uimm[4:0] for VSETIVLI
- in_vtype  in  XLEN  requested vtype, zero-extended immediate or rs2 value
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_rd_data  out  XLEN  new vl
- out_rd_we  out  1  equals !rd_x0 of the uop in S2
- vtype_q  out  XLEN  architectural vtype
- vl_q  out  XLEN  architectural vl
- vill_q  out  1  equals vtype_q[XLEN-1]

## Operation
- Pipeline: S1 register captures the uop; S1 logic computes legality, VLMAX and vl; S2 register holds the result.
- Commit: the architectural registers update only on an S2 handshake (out_valid && out_ready).
- Legality: vill is set when any of the following hold:
  - vtype[XLEN-2:8] != 0
  - vlmul == 3'b100
  - vsew is not SEW8/16/32 (SEW64 is subject to the macro below)
  - SEW > ELEN*LMUL for fractional LMUL, e.g. SEW32 with LMUL1_2 when ELEN=32
- VLMAX = (VLEN >> (3+vsew)) shifted left by vlmul for LMUL >= 1, or shifted right by 1 or 2 for LMUL1_2 or LMUL1_4. It is computed with shifts only; no multiplier.
- AVL selection:
  - VSETIVLI: zero-extended uimm5.
  - rs1 != x0: in_avl.
  - rs1 == x0 and rd != x0: all-ones, so vl = VLMAX.
  - rs1 == x0 and rd == x0: keep the current vl. If current vl > new VLMAX, set vill.
- vl = min(AVL, VLMAX).
- On vill: vl = 0, vtype = 1 << (XLEN-1).
- Forwarding: "current vl/vtype" means the S2 result when s2_valid, otherwise vl_q/vtype_q. A back-to-back keep-vl uop therefore sees the older uop's result.
- Flush clears s1_valid and s2_valid on the next edge. If flush coincides with an S2 handshake, flush wins: no commit. in_ready is 0 during the flush cycle.
- Reset, asynchronous, clears:
  - s1_valid, s2_valid, out_valid = 0
  - vl_q = 0
  - vtype_q = 1 << (XLEN-1), so vill_q = 1
  - out_rd_data = 0, out_rd_we = 0

## Timing
- Latency: in handshake at cycle N gives out_valid at cycle N+2 when there is no backpressure.
- Throughput: one uop per cycle.
- s2_load = s1_valid && (!s2_valid || out_ready).
- in_ready = !flush && (!s1_valid || s2_load).
- Backpressure: out_ready low holds S2 and then S1 stable; outputs do not change while out_valid && !out_ready.
- Architectural registers change exactly on the edge that ends a committing S2 handshake; dispatch sees the new value the next cycle.
- Reset may assert mid-operation; all in-flight uops are dropped.

## Configuration
- RVV_VSETVL_SEW64_EN defined: vsew = 3'b011 (SEW64) is legal when ELEN == 64, and VLMAX uses VLEN >> 6.
- Undefined: vsew = 3'b011 always sets vill, and the SEW64 datapath is absent.

## Structure
- Shared package rvv_tb_pkg / RTL define package holds vtype_t, sew_e (SEW64 member added), lmul_e and the new vset_op_e.
- Sub-module rvv_vlmax_calc: combinational legality check plus VLMAX computation from (vsew, vlmul), parametrised by VLEN/ELEN. It is instantiated in S1.

## Test plan
- Reset → vill_q=1, vl_q=0, out_valid=0, in_ready=1.
- VSETVLI, avl=20, vtype=0x00 (SEW8, LMUL1), VLEN=128 → out_rd_data=16 at N+2; vl_q=16 and vtype_q=0x00 after the handshake.
- VSETIVLI, uimm=5, vtype=0x11 (SEW32, LMUL2) → vl=5. Separately, rs1=x0 and rd!=x0 with vtype=0x0B (SEW16, LMUL8) → vl=64.
- Back-to-back, out_ready=1:
  - VSETVLI avl=10, vtype=0x00, then rs1=rd=x0 with vtype=0x09 (VLMAX 16) → second result keeps vl=10 via forwarding.
  - Then rs1=rd=x0 with vtype=0x10 (VLMAX 4) → vill, vl=0, vtype_q=0x8000_0000.
- vtype=0x16 (SEW32, LMUL1_4, ELEN=32) → vill, vl=0. vtype=0x100 (reserved bit) → vill.
- Hold out_ready=0 for 3 cycles with 2 uops in flight → in_ready=0 and outputs stable. Then assert flush → no commit, vl_q unchanged, out_valid=0 next cycle.

Source files
------------

// File: rtl/rvv_vsetvl_unit_pkg.sv
// Shared types for the RVV vector-configuration unit: vtype fields, SEW/LMUL
// encodings and the vset uop opcode.
package rvv_vsetvl_unit_pkg;

  typedef enum logic [1:0] {
    VSETVLI  = 2'd0,
    VSETIVLI = 2'd1,
    VSETVL   = 2'd2
  } vset_op_e;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } sew_e;

  typedef enum logic [2:0] {
    LMUL1    = 3'd0,
    LMUL2    = 3'd1,
    LMUL4    = 3'd2,
    LMUL8    = 3'd3,
    LMUL_RSV = 3'd4,
    LMUL1_8  = 3'd5,
    LMUL1_4  = 3'd6,
    LMUL1_2  = 3'd7
  } lmul_e;

  typedef struct packed {
    logic  vma;
    logic  vta;
    sew_e  vsew;
    lmul_e vlmul;
  } vtype_t;

  // Right-shift amount for fractional LMUL: 1/8 -> 3, 1/4 -> 2, 1/2 -> 1.
  function automatic logic [2:0] frac_shift(input logic [2:0] vlmul);
    return 3'd4 - {1'b0, vlmul[1:0]};
  endfunction

endpackage

// File: rtl/rvv_vlmax_calc.sv
// Combinational vtype legality and VLMAX = VLEN/SEW*LMUL using shifts only.
// SEW64 support is compiled in with RVV_VSETVL_SEW64_EN.
module rvv_vlmax_calc
  import rvv_vsetvl_unit_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int ELEN = 32
) (
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  input  logic            rsv,
  output logic            vill,
  output logic [XLEN-1:0] vlmax
);

  logic            sew_ok;
  logic            frac_ok;
  logic [10:0]     sew_bits;
  logic [XLEN-1:0] base;

  always_comb begin
`ifdef RVV_VSETVL_SEW64_EN
    sew_ok = (vsew <= SEW32) || ((vsew == SEW64) && (ELEN == 64));
    base   = XLEN'(VLEN) >> ({1'b0, vsew} + 4'd3);
`else
    sew_ok = (vsew <= SEW32);
    base   = XLEN'(VLEN) >> ({2'b00, vsew[1:0]} + 4'd3);
`endif
    sew_bits = 11'd8 << vsew;
    frac_ok  = 1'b1;
    if (!vlmul[2]) begin
      vlmax = base << vlmul[1:0];
    end else begin
      vlmax   = base >> frac_shift(vlmul);
      // SEW must fit in ELEN*LMUL when LMUL is fractional
      frac_ok = int'(sew_bits) <= (ELEN >> frac_shift(vlmul));
    end
    vill = rsv || (vlmul == LMUL_RSV) || !sew_ok || !frac_ok;
  end

endmodule

// File: rtl/rvv_vsetvl_unit.sv
// Two-stage vsetvl/vsetivli/vsetvl unit holding architectural vtype/vl.
// Optional SEW64 support: define RVV_VSETVL_SEW64_EN.
module rvv_vsetvl_unit
  import rvv_vsetvl_unit_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int ELEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  vset_op_e        in_op,
  input  logic            in_rs1_x0,
  input  logic            in_rd_x0,
  input  logic [XLEN-1:0] in_avl,
  input  logic [XLEN-1:0] in_vtype,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd_data,
  output logic            out_rd_we,
  output logic [XLEN-1:0] vtype_q,
  output logic [XLEN-1:0] vl_q,
  output logic            vill_q
);

  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    vset_op_e        op;
    logic            rs1_x0;
    logic            rd_x0;
    logic [XLEN-1:0] avl;
    logic [XLEN-1:0] vtype;
  } uop_t;

  typedef struct packed {
    logic [XLEN-1:0] vl;
    logic [XLEN-1:0] vtype;
    logic            rd_we;
  } res_t;

  uop_t            s1_q, s1_d;
  res_t            s2_q, s2_d, res;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] vl_d, vtype_d;
  logic            s2_load, commit, keep_vl, vill, cfg_vill, vtype_rsv;
  logic [XLEN-1:0] cur_vl, avl, vlmax;

  // A set top bit in a requested vtype is treated like any other reserved bit.
  assign vtype_rsv = |s1_q.vtype[XLEN-1:8];

  rvv_vlmax_calc #(.VLEN(VLEN), .XLEN(XLEN), .ELEN(ELEN)) u_vlmax (
    .vsew  (s1_q.vtype[5:3]),
    .vlmul (s1_q.vtype[2:0]),
    .rsv   (vtype_rsv),
    .vill  (cfg_vill),
    .vlmax (vlmax)
  );

  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !flush && (!s1_valid_q || s2_load);
    commit   = s2_valid_q && out_ready && !flush;

    // The older uop sitting in S2 is the "current" state for the one in S1
    cur_vl  = s2_valid_q ? s2_q.vl : vl_q;
    keep_vl = (s1_q.op != VSETIVLI) && s1_q.rs1_x0 && s1_q.rd_x0;
    if (s1_q.op == VSETIVLI) avl = {{(XLEN-5){1'b0}}, s1_q.avl[4:0]};
    else if (!s1_q.rs1_x0)   avl = s1_q.avl;
    else if (!s1_q.rd_x0)    avl = '1;
    else                     avl = cur_vl;
    vill = cfg_vill || (keep_vl && (cur_vl > vlmax));

    res.vl    = vill ? '0 : ((avl < vlmax) ? avl : vlmax);
    res.vtype = vill ? VILL_VTYPE : s1_q.vtype;
    res.rd_we = !s1_q.rd_x0;

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid)
        s1_d = '{op: in_op, rs1_x0: in_rs1_x0, rd_x0: in_rd_x0, avl: in_avl, vtype: in_vtype};
    end
    if (flush) s1_valid_d = 1'b0;

    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_d       = res;
      s2_valid_d = 1'b1;
    end else if (commit) begin
      s2_valid_d = 1'b0;
    end
    if (flush) s2_valid_d = 1'b0;

    vl_d    = commit ? s2_q.vl    : vl_q;
    vtype_d = commit ? s2_q.vtype : vtype_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
      vl_q       <= '0;
      vtype_q    <= VILL_VTYPE;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
      vl_q       <= vl_d;
      vtype_q    <= vtype_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_rd_data = s2_q.vl;
  assign out_rd_we   = s2_q.rd_we;
  assign vill_q      = vtype_q[XLEN-1];

endmodule
